// File: rtl/avalon_mm_initiator_pkg.sv
// Shared types and constants for the single-outstanding Avalon-MM initiator.
package avalon_mm_initiator_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      RD_REQ,
      RD_WAIT,
      RSP
   } state_e;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

   localparam int DEFAULT_TIMEOUT_CYCLES = 255;
   localparam int TIMER_WIDTH            = 16;

endpackage

// File: rtl/avalon_mm_initiator_if.sv
// Command, completion and Avalon-MM signal bundle; master = initiator side, slave = user/responder side.
interface avalon_mm_initiator_if #(
   parameter int ADDR_WIDTH = 4
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [31:0]           cmd_wdata;
   logic [3:0]            cmd_strb;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic                  rsp_write;
   logic [31:0]           rsp_data;
   logic [1:0]            rsp_resp;
   logic                  rsp_timeout;

   logic [ADDR_WIDTH-1:0] avl_mm_addr;
   logic                  avl_mm_read;
   logic                  avl_mm_write;
   logic [31:0]           avl_mm_writedata;
   logic [3:0]            avl_mm_byteenable;
   logic                  avl_mm_waitrequest;
   logic [31:0]           avl_mm_readdata;
   logic                  avl_mm_readdatavalid;
   logic [1:0]            avl_mm_response;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
      output cmd_ready,
      output rsp_valid, rsp_write, rsp_data, rsp_resp, rsp_timeout,
      input  rsp_ready,
      output avl_mm_addr, avl_mm_read, avl_mm_write, avl_mm_writedata, avl_mm_byteenable,
      input  avl_mm_waitrequest, avl_mm_readdata, avl_mm_readdatavalid, avl_mm_response
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
      input  cmd_ready,
      input  rsp_valid, rsp_write, rsp_data, rsp_resp, rsp_timeout,
      output rsp_ready,
      input  avl_mm_addr, avl_mm_read, avl_mm_write, avl_mm_writedata, avl_mm_byteenable,
      output avl_mm_waitrequest, avl_mm_readdata, avl_mm_readdatavalid, avl_mm_response
   );

endinterface

// File: rtl/avl_timeout_counter.sv
// Read-response watchdog: counts enabled cycles since clear and flags the last allowed cycle.
module avl_timeout_counter
   import avalon_mm_initiator_pkg::*;
#(
   parameter int WIDTH = TIMER_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear_i,
   input  logic             enable_i,
   input  logic [WIDTH-1:0] limit_i,
   output logic             expired_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Asserted during the limit-th enabled cycle, so the waiting state lasts exactly limit cycles.
   assign expired_o = enable_i && (count_q == (limit_i - 1'b1));

endmodule

// File: rtl/avalon_mm_initiator.sv
// Single-outstanding Avalon-MM initiator: command in, one bus transfer, one registered completion out.
module avalon_mm_initiator
   import avalon_mm_initiator_pkg::*;
#(
   parameter int ADDR_WIDTH     = 4,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                   clk,
   input  logic                   rst,
   avalon_mm_initiator_if.master  bus
);

   localparam logic [TIMER_WIDTH-1:0] TIMEOUT_LIMIT = TIMER_WIDTH'(TIMEOUT_CYCLES);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] avl_addr_q, avl_addr_d;
   logic                  avl_read_q, avl_read_d;
   logic                  avl_write_q, avl_write_d;
   logic [31:0]           avl_wdata_q, avl_wdata_d;
   logic [3:0]            avl_be_q, avl_be_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_write_q, rsp_write_d;
   logic [31:0]           rsp_data_q, rsp_data_d;
   logic [1:0]            rsp_resp_q, rsp_resp_d;
   logic                  rsp_timeout_q, rsp_timeout_d;

   logic timer_clear;
   logic timer_enable;
   logic timer_expired;

   avl_timeout_counter #(
      .WIDTH (TIMER_WIDTH)
   ) u_timeout (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (timer_clear),
      .enable_i  (timer_enable),
      .limit_i   (TIMEOUT_LIMIT),
      .expired_o (timer_expired)
   );

   always_comb begin
      state_d       = state_q;
      avl_addr_d    = avl_addr_q;
      avl_read_d    = avl_read_q;
      avl_write_d   = avl_write_q;
      avl_wdata_d   = avl_wdata_q;
      avl_be_d      = avl_be_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_write_d   = rsp_write_q;
      rsp_data_d    = rsp_data_q;
      rsp_resp_d    = rsp_resp_q;
      rsp_timeout_d = rsp_timeout_q;
      timer_clear   = 1'b0;
      timer_enable  = (state_q == RD_WAIT);

      unique case (state_q)
         IDLE: begin
            if (bus.cmd_valid) begin
               avl_addr_d  = bus.cmd_addr;
               avl_wdata_d = bus.cmd_write ? bus.cmd_wdata : 32'h0;
               avl_be_d    = bus.cmd_write ? bus.cmd_strb : 4'hF;
               avl_write_d = bus.cmd_write;
               avl_read_d  = !bus.cmd_write;
               state_d     = bus.cmd_write ? WR_REQ : RD_REQ;
            end
         end
         WR_REQ: begin
            if (!bus.avl_mm_waitrequest) begin
               avl_write_d   = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_write_d   = 1'b1;
               rsp_data_d    = 32'h0;
               rsp_resp_d    = OKAY;
               rsp_timeout_d = 1'b0;
               state_d       = RSP;
            end
         end
         RD_REQ: begin
            // readdatavalid in this state is never a reply to our read; it is not looked at.
            if (!bus.avl_mm_waitrequest) begin
               avl_read_d  = 1'b0;
               timer_clear = 1'b1;
               state_d     = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (bus.avl_mm_readdatavalid) begin
               rsp_valid_d   = 1'b1;
               rsp_write_d   = 1'b0;
               rsp_data_d    = bus.avl_mm_readdata;
               rsp_resp_d    = bus.avl_mm_response;
               rsp_timeout_d = 1'b0;
               state_d       = RSP;
            end else if (timer_expired) begin
               rsp_valid_d   = 1'b1;
               rsp_write_d   = 1'b0;
               rsp_data_d    = 32'h0;
               rsp_resp_d    = SLVERR;
               rsp_timeout_d = 1'b1;
               state_d       = RSP;
            end
         end
         RSP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         avl_addr_q    <= '0;
         avl_read_q    <= 1'b0;
         avl_write_q   <= 1'b0;
         avl_wdata_q   <= 32'h0;
         avl_be_q      <= 4'h0;
         rsp_valid_q   <= 1'b0;
         rsp_write_q   <= 1'b0;
         rsp_data_q    <= 32'h0;
         rsp_resp_q    <= 2'b00;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         avl_addr_q    <= avl_addr_d;
         avl_read_q    <= avl_read_d;
         avl_write_q   <= avl_write_d;
         avl_wdata_q   <= avl_wdata_d;
         avl_be_q      <= avl_be_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_write_q   <= rsp_write_d;
         rsp_data_q    <= rsp_data_d;
         rsp_resp_q    <= rsp_resp_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   assign bus.cmd_ready         = (state_q == IDLE);
   assign bus.rsp_valid         = rsp_valid_q;
   assign bus.rsp_write         = rsp_write_q;
   assign bus.rsp_data          = rsp_data_q;
   assign bus.rsp_resp          = rsp_resp_q;
   assign bus.rsp_timeout       = rsp_timeout_q;
   assign bus.avl_mm_addr       = avl_addr_q;
   assign bus.avl_mm_read       = avl_read_q;
   assign bus.avl_mm_write      = avl_write_q;
   assign bus.avl_mm_writedata  = avl_wdata_q;
   assign bus.avl_mm_byteenable = avl_be_q;

endmodule

// File: tb/tb_avalon_mm_initiator.sv
// Table-driven bench for avalon_mm_initiator with a completion scoreboard and reset/stall corner cases.
module tb_avalon_mm_initiator;
   import avalon_mm_initiator_pkg::*;

   localparam int AW = 4;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   avalon_mm_initiator_if #(.ADDR_WIDTH(AW)) bus ();

   avalon_mm_initiator #(
      .ADDR_WIDTH     (AW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic          write;
      logic [AW-1:0] addr;
      logic [31:0]   wdata;
      logic [3:0]    strb;
      int            wait_n;
      int            rdv_delay;
      logic          stray;
      logic [31:0]   rdata;
      logic [1:0]    resp;
      int            hold_n;
      logic [31:0]   exp_data;
      logic [1:0]    exp_resp;
      logic          exp_timeout;
   } vec_t;

   typedef struct {
      logic        write;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        timeout;
   } rsp_t;

   vec_t vecs[8];
   rsp_t sb_q[$];
   int   tests = 0;
   int   fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      rsp_t exp;
      rsp_t got;
      int   n;
      int   k;
      int   exp_k;
      logic acc;

      n = 0;
      while (!bus.cmd_ready && n < 50) begin
         tick();
         n++;
      end
      chk("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);

      bus.cmd_valid = 1'b1;
      bus.cmd_write = v.write;
      bus.cmd_addr  = v.addr;
      bus.cmd_wdata = v.wdata;
      bus.cmd_strb  = v.strb;
      exp.write     = v.write;
      exp.data      = v.exp_data;
      exp.resp      = v.exp_resp;
      exp.timeout   = v.exp_timeout;
      sb_q.push_back(exp);
      tick();
      bus.cmd_valid = 1'b0;

      n   = 0;
      acc = 1'b0;
      while (!acc && n < 50) begin
         chk("avl_write", 32'(bus.avl_mm_write), 32'(v.write));
         chk("avl_read", 32'(bus.avl_mm_read), 32'(!v.write));
         chk("avl_addr", 32'(bus.avl_mm_addr), 32'(v.addr));
         chk("avl_be", 32'(bus.avl_mm_byteenable), 32'(v.write ? v.strb : 4'hF));
         if (v.write) chk("avl_wdata", bus.avl_mm_writedata, v.wdata);
         bus.avl_mm_waitrequest   = (n < v.wait_n);
         acc                      = !bus.avl_mm_waitrequest;
         bus.avl_mm_readdatavalid = v.stray;
         bus.avl_mm_readdata      = 32'hBADBAD00;
         bus.avl_mm_response      = DECERR;
         tick();
         n++;
      end
      bus.avl_mm_waitrequest   = 1'b0;
      bus.avl_mm_readdatavalid = 1'b0;
      chk("req_cycles", 32'(n), 32'(v.wait_n + 1));
      chk("strobes_low", 32'({bus.avl_mm_read, bus.avl_mm_write}), 32'd0);

      k = 0;
      while (!bus.rsp_valid && k < 100) begin
         k++;
         bus.avl_mm_readdatavalid = (k == v.rdv_delay);
         bus.avl_mm_readdata      = v.rdata;
         bus.avl_mm_response      = v.resp;
         tick();
      end
      bus.avl_mm_readdatavalid = 1'b0;
      bus.avl_mm_readdata      = 32'hBADBAD00;
      exp_k = v.write ? 0 : ((v.rdv_delay != 0) ? v.rdv_delay : TO);
      chk("wait_cycles", 32'(k), 32'(exp_k));

      exp         = sb_q.pop_front();
      got.write   = bus.rsp_write;
      got.data    = bus.rsp_data;
      got.resp    = bus.rsp_resp;
      got.timeout = bus.rsp_timeout;
      chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("rsp_write", 32'(got.write), 32'(exp.write));
      chk("rsp_data", got.data, exp.data);
      chk("rsp_resp", 32'(got.resp), 32'(exp.resp));
      chk("rsp_timeout", 32'(got.timeout), 32'(exp.timeout));

      for (int h = 0; h < v.hold_n; h++) begin
         bus.rsp_ready = 1'b0;
         bus.cmd_valid = 1'b1;
         bus.cmd_write = 1'b0;
         bus.cmd_addr  = 4'hC;
         tick();
         chk("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
         chk("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
         chk("hold_rsp_write", 32'(bus.rsp_write), 32'(exp.write));
         chk("hold_rsp_data", bus.rsp_data, exp.data);
         chk("hold_rsp_resp", 32'(bus.rsp_resp), 32'(exp.resp));
         chk("hold_rsp_timeout", 32'(bus.rsp_timeout), 32'(exp.timeout));
      end
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      chk("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
      chk("cmd_ready_after", 32'(bus.cmd_ready), 32'd1);

      $display("[TB] txn %0d write=%0d addr=0x%0h data=0x%08h resp=%0d timeout=%0d wait=%0d",
               idx, got.write, v.addr, got.data, got.resp, got.timeout, k);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.cmd_valid            = 1'b0;
      bus.cmd_write            = 1'b0;
      bus.cmd_addr             = '0;
      bus.cmd_wdata            = 32'h0;
      bus.cmd_strb             = 4'h0;
      bus.rsp_ready            = 1'b0;
      bus.avl_mm_waitrequest   = 1'b0;
      bus.avl_mm_readdata      = 32'h0;
      bus.avl_mm_readdatavalid = 1'b0;
      bus.avl_mm_response      = 2'b00;

      //          wr    addr   wdata         strb   wt rdv stray  rdata         resp    hold exp_data      exp_resp tmo
      vecs[0] = '{1'b1, 4'd2,  32'hDEADBEEF, 4'hF,  3, 0, 1'b0, 32'h0,        OKAY,   0, 32'h0,        OKAY,   1'b0};
      vecs[1] = '{1'b0, 4'd1,  32'h0,        4'h0,  0, 1, 1'b0, 32'h12345678, OKAY,   0, 32'h12345678, OKAY,   1'b0};
      vecs[2] = '{1'b0, 4'd9,  32'h0,        4'h0,  0, 2, 1'b0, 32'h0,        DECERR, 0, 32'h0,        DECERR, 1'b0};
      vecs[3] = '{1'b0, 4'd3,  32'h0,        4'h0,  1, 0, 1'b0, 32'hAAAAAAAA, OKAY,   0, 32'h0,        SLVERR, 1'b1};
      vecs[4] = '{1'b1, 4'd5,  32'h0000A5A5, 4'h5,  0, 0, 1'b1, 32'h0,        OKAY,   5, 32'h0,        OKAY,   1'b0};
      vecs[5] = '{1'b0, 4'd7,  32'h0,        4'h0,  2, 8, 1'b1, 32'hCAFEF00D, 2'b01,  0, 32'hCAFEF00D, 2'b01,  1'b0};
      vecs[6] = '{1'b0, 4'd15, 32'h0,        4'h0,  0, 3, 1'b0, 32'h0BADBEEF, SLVERR, 0, 32'h0BADBEEF, SLVERR, 1'b0};
      vecs[7] = '{1'b1, 4'd0,  32'h76543210, 4'h8,  1, 0, 1'b0, 32'h0,        OKAY,   1, 32'h0,        OKAY,   1'b0};

      // Reset values while rst is held
      tick();
      tick();
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      chk("rst_avl_strobes", 32'({bus.avl_mm_read, bus.avl_mm_write}), 32'd0);
      chk("rst_avl_addr", 32'(bus.avl_mm_addr), 32'd0);
      chk("rst_avl_wdata", bus.avl_mm_writedata, 32'd0);
      chk("rst_avl_be", 32'(bus.avl_mm_byteenable), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_data", bus.rsp_data, 32'd0);
      chk("rst_rsp_flags", 32'({bus.rsp_resp, bus.rsp_write, bus.rsp_timeout}), 32'd0);
      rst = 1'b0;
      tick();
      chk("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

      for (int i = 0; i < 8; i++) begin
         run_vec(vecs[i], i);
      end

      // Reset in the middle of RD_WAIT aborts the read; a late readdatavalid must be ignored
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 4'd4;
      tick();
      bus.cmd_valid          = 1'b0;
      bus.avl_mm_waitrequest = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      #2;
      chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("abort_avl_read", 32'(bus.avl_mm_read), 32'd0);
      chk("abort_avl_addr", 32'(bus.avl_mm_addr), 32'd0);
      chk("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      #2;
      rst = 1'b0;
      bus.avl_mm_readdatavalid = 1'b1;
      bus.avl_mm_readdata      = 32'h11111111;
      bus.avl_mm_response      = OKAY;
      tick();
      bus.avl_mm_readdatavalid = 1'b0;
      chk("abort_cmd_ready_edge", 32'(bus.cmd_ready), 32'd1);
      for (int c = 0; c < TO + 4; c++) begin
         chk("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
         chk("abort_idle", 32'(bus.cmd_ready), 32'd1);
         tick();
      end
      $display("[TB] txn abort read addr=0x4 reset during RD_WAIT, no completion expected");

      run_vec(vecs[1], 8);

      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/avalon_mm_initiator.md
AVALON_MM_INITIATOR -- requirements
Module: avalon_mm_initiator

Interface
REQ-001 Parameter ADDR_WIDTH, default 4: width of avl_mm_addr and cmd_addr.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: maximum cycles waited for readdatavalid after a read is accepted; 1..65535.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  word address
- cmd_wdata  in  32  write data
- cmd_strb  in  4  byte enables (write only)
- rsp_valid  out  1  completion available
- rsp_ready  in  1  completion consumed
- rsp_write  out  1  completion belongs to a write
- rsp_data  out  32  read data (0 for writes)
- rsp_resp  out  2  Avalon response code
- rsp_timeout  out  1  read timed out
- avl_mm_addr  out  ADDR_WIDTH  Avalon address
- avl_mm_read  out  1  Avalon read
- avl_mm_write  out  1  Avalon write
- avl_mm_writedata  out  32  Avalon write data
- avl_mm_byteenable  out  4  Avalon byte enables
- avl_mm_waitrequest  in  1  responder stall
- avl_mm_readdata  in  32  responder read data
- avl_mm_readdatavalid  in  1  responder data valid
- avl_mm_response  in  2  responder response code

Function
REQ-005 One outstanding transaction only; no bursts; 32-bit words only.
REQ-006 FSM states: IDLE, WR_REQ, RD_REQ, RD_WAIT, RSP.
REQ-007 cmd_ready SHALL equal (state == IDLE); commands are captured into registers on the cmd_valid && cmd_ready cycle.
REQ-008 IDLE -> WR_REQ (cmd_write=1) or RD_REQ (cmd_write=0) on capture.
REQ-009 In WR_REQ, avl_mm_write=1 with registered addr/data/byteenable, held stable until a cycle with avl_mm_waitrequest=0.
- On that cycle -> RSP with rsp_write=1, rsp_resp=2'b00, rsp_data=0.
REQ-010 In RD_REQ, avl_mm_read=1 with registered addr, held until a cycle with avl_mm_waitrequest=0 -> RD_WAIT; avl_mm_byteenable=4'hF for reads.
REQ-011 If avl_mm_readdatavalid is high on the same cycle the read is accepted, it SHALL be ignored (responder data is at least 1 cycle later).
REQ-012 In RD_WAIT, on avl_mm_readdatavalid=1 -> RSP.
- rsp_data = avl_mm_readdata, rsp_resp = avl_mm_response, rsp_timeout=0.
REQ-013 Timeout counter (16-bit): cleared on entry to RD_WAIT, increments each RD_WAIT cycle.
- When it reaches TIMEOUT_CYCLES without readdatavalid -> RSP with rsp_data=0, rsp_resp=2'b10, rsp_timeout=1.
- readdatavalid on the same cycle as expiry wins (normal completion).
REQ-014 In RSP, rsp_valid=1 and rsp_* SHALL be held stable until rsp_ready=1, then -> IDLE.
- A new command SHALL be accepted no earlier than the following cycle.
REQ-015 avl_mm_read and avl_mm_write SHALL never be high simultaneously and SHALL be low outside WR_REQ/RD_REQ.
REQ-016 Stray avl_mm_readdatavalid outside RD_WAIT SHALL be ignored.
REQ-017 Every output SHALL be driven from a register (no combinational input-to-output path), except cmd_ready, which is decoded from state.

Reset
REQ-018 While rst=1, state=IDLE and:
- avl_mm_read=0, avl_mm_write=0, avl_mm_addr=0, avl_mm_writedata=0, avl_mm_byteenable=0
- rsp_valid=0, rsp_data=0, rsp_resp=0, rsp_write=0, rsp_timeout=0
- timeout counter=0
REQ-019 Reset asserted mid-transaction SHALL abort it with no completion issued; cmd_ready=1 on the first clock edge after release.

Structure
REQ-020 A shared package SHALL hold:
- the state enum
- response code constants OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11
- the default TIMEOUT_CYCLES
REQ-021 The timeout counter is a natural sub-module, avl_timeout_counter (clear, enable, limit, expired); all other logic is flat.

Verification
REQ-022 Write 0xDEADBEEF, strb 4'hF, to addr 2 with waitrequest held 3 cycles:
- avl_mm_write high exactly 4 cycles with stable signals
- then rsp_valid, rsp_write=1, rsp_resp=00
REQ-023 Read addr 1, waitrequest=0, readdatavalid one cycle later with 0x12345678, response 00:
- rsp_data=0x12345678, rsp_resp=00, rsp_timeout=0
REQ-024 Read to an unmapped address, responder returns response 2'b11, data 0:
- rsp_resp=11, rsp_data=0
REQ-025 Read, no readdatavalid, TIMEOUT_CYCLES=8:
- rsp_valid after 8 RD_WAIT cycles with rsp_resp=10, rsp_timeout=1
REQ-026 rsp_ready held low 5 cycles with cmd_valid high:
- cmd_ready=0 and rsp_* stable throughout
- next command accepted the cycle after the rsp_ready handshake
REQ-027 rst pulsed during RD_WAIT, then readdatavalid arrives:
- no rsp_valid issued, FSM in IDLE
